// File: rtl/axi_riscv_lrsc_rsv_table.sv
// LR/SC reservation table for the RISC-V atomics adapter.
// Holds up to NUM_RSV reservations (one per AXI ID) at 2^GRANULE_LOG2-byte granularity, with
// optional timeout expiry. The adapter registers LR reads, queries SC outcomes and snoops every
// plain write. This block does not handle the AXI channels.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   lr_valid_i/lr_ready_o      LR registration handshake (lr_id_i, lr_addr_i)
//   sc_valid_i/sc_ready_o      SC query handshake (sc_id_i, sc_addr_i)
//   sc_rsp_valid_o/_ready_i    registered SC result, sc_rsp_ok_o = 1 means the SC may write
//   wr_valid_i                 plain write snoop over [wr_first_addr_i, wr_last_addr_i]
//   rsv_count_o                number of occupied slots (registered)
//   evict_o                    one-cycle pulse when an LR displaced a live reservation
module axi_riscv_lrsc_rsv_table #(
  parameter int unsigned               AXI_ADDR_WIDTH = 64,
  parameter int unsigned               AXI_ID_WIDTH   = 4,
  parameter int unsigned               NUM_RSV        = 4,
  parameter int unsigned               GRANULE_LOG2   = 3,
  parameter int unsigned               TIMEOUT_CYCLES = 0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BEGIN     = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_END       = '1,
  localparam int unsigned              CntWidth       = $clog2(NUM_RSV + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      lr_valid_i,
  output logic                      lr_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]   lr_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] lr_addr_i,
  input  logic                      sc_valid_i,
  output logic                      sc_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]   sc_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] sc_addr_i,
  output logic                      sc_rsp_valid_o,
  input  logic                      sc_rsp_ready_i,
  output logic                      sc_rsp_ok_o,
  input  logic                      wr_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_first_addr_i,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_last_addr_i,
  output logic [CntWidth-1:0]       rsv_count_o,
  output logic                      evict_o
);

  localparam int unsigned GranW = AXI_ADDR_WIDTH - GRANULE_LOG2;
  localparam int unsigned IdxW  = (NUM_RSV > 1) ? $clog2(NUM_RSV) : 1;
  localparam int unsigned TmoW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [NUM_RSV-1:0]      valid_q, valid_d;
  logic [AXI_ID_WIDTH-1:0] id_q   [NUM_RSV];
  logic [AXI_ID_WIDTH-1:0] id_d   [NUM_RSV];
  logic [GranW-1:0]        gran_q [NUM_RSV];
  logic [GranW-1:0]        gran_d [NUM_RSV];
  logic [TmoW-1:0]         tmo_q  [NUM_RSV];
  logic [TmoW-1:0]         tmo_d  [NUM_RSV];
  logic [IdxW-1:0]         rr_q, rr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_ok_q, rsp_ok_d;
  logic                    evict_q, evict_d;
  logic [CntWidth-1:0]     count_q, count_d;

  logic [AXI_ADDR_WIDTH-1:0] addr_begin, addr_end;
  logic [GranW-1:0]          lr_gran, sc_gran, wr_first_gran, wr_last_gran;
  logic                      lr_hs, sc_hs, lr_in_range, sc_in_range, wr_active;
  logic                      sc_ok, lr_found;
  logic [IdxW-1:0]           lr_idx;

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a,
                                    input logic [AXI_ADDR_WIDTH-1:0] lo,
                                    input logic [AXI_ADDR_WIDTH-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  assign addr_begin    = ADDR_BEGIN;
  assign addr_end      = ADDR_END;
  assign lr_gran       = lr_addr_i[AXI_ADDR_WIDTH-1:GRANULE_LOG2];
  assign sc_gran       = sc_addr_i[AXI_ADDR_WIDTH-1:GRANULE_LOG2];
  assign wr_first_gran = wr_first_addr_i[AXI_ADDR_WIDTH-1:GRANULE_LOG2];
  assign wr_last_gran  = wr_last_addr_i[AXI_ADDR_WIDTH-1:GRANULE_LOG2];
  assign lr_in_range   = in_range(lr_addr_i, addr_begin, addr_end);
  assign sc_in_range   = in_range(sc_addr_i, addr_begin, addr_end);
  assign wr_active     = wr_valid_i && (wr_last_addr_i >= wr_first_addr_i);

  assign lr_ready_o     = !rst_i;
  assign sc_ready_o     = !rsp_valid_q || sc_rsp_ready_i;
  assign lr_hs          = lr_valid_i && lr_ready_o;
  assign sc_hs          = sc_valid_i && sc_ready_o;
  assign sc_rsp_valid_o = rsp_valid_q;
  assign sc_rsp_ok_o    = rsp_ok_q;
  assign rsv_count_o    = count_q;
  assign evict_o        = evict_q;

  always_comb begin
    valid_d     = valid_q;
    id_d        = id_q;
    gran_d      = gran_q;
    tmo_d       = tmo_q;
    rr_d        = rr_q;
    evict_d     = 1'b0;
    sc_ok       = 1'b0;
    lr_found    = 1'b0;
    lr_idx      = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_ok_d    = rsp_ok_q;
    count_d     = '0;

    // SC outcome from pre-edge state. A counter at 1 expires on this edge, so it no longer counts.
    for (int i = 0; i < int'(NUM_RSV); i++) begin
      if (valid_q[i] && id_q[i] == sc_id_i && gran_q[i] == sc_gran &&
          (TIMEOUT_CYCLES == 0 || tmo_q[i] != TmoW'(1))) begin
        sc_ok = sc_in_range;
      end
    end

    // Invalidations: expiry, SC, snoop; all judged on pre-edge state.
    for (int i = 0; i < int'(NUM_RSV); i++) begin
      if (TIMEOUT_CYCLES > 0 && valid_q[i]) begin
        tmo_d[i] = tmo_q[i] - TmoW'(1);
        if (tmo_q[i] == TmoW'(1)) valid_d[i] = 1'b0;
      end
      if (sc_hs && (id_q[i] == sc_id_i || (sc_ok && gran_q[i] == sc_gran))) valid_d[i] = 1'b0;
      if (wr_active && gran_q[i] >= wr_first_gran && gran_q[i] <= wr_last_gran) valid_d[i] = 1'b0;
    end

    // LR install last so it wins over any same-cycle invalidation of its own slot.
    if (lr_hs && lr_in_range) begin
      for (int i = int'(NUM_RSV) - 1; i >= 0; i--) begin
        if (valid_d[i] && id_q[i] == lr_id_i) begin
          lr_found = 1'b1;
          lr_idx   = IdxW'(i);
        end
      end
      if (!lr_found) begin
        for (int i = int'(NUM_RSV) - 1; i >= 0; i--) begin
          if (!valid_d[i]) begin
            lr_found = 1'b1;
            lr_idx   = IdxW'(i);
          end
        end
      end
      if (!lr_found) begin
        lr_idx  = rr_q;
        evict_d = 1'b1;
        rr_d    = (rr_q == IdxW'(NUM_RSV - 1)) ? '0 : rr_q + 1'b1;
      end
      valid_d[lr_idx] = 1'b1;
      id_d[lr_idx]    = lr_id_i;
      gran_d[lr_idx]  = lr_gran;
      tmo_d[lr_idx]   = TmoW'(TIMEOUT_CYCLES);
    end

    if (sc_hs) begin
      rsp_valid_d = 1'b1;
      rsp_ok_d    = sc_ok;
    end else if (sc_rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    for (int i = 0; i < int'(NUM_RSV); i++) begin
      count_d = count_d + CntWidth'(valid_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      evict_q     <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < int'(NUM_RSV); i++) begin
        id_q[i]   <= '0;
        gran_q[i] <= '0;
        tmo_q[i]  <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ok_q    <= rsp_ok_d;
      evict_q     <= evict_d;
      count_q     <= count_d;
      for (int i = 0; i < int'(NUM_RSV); i++) begin
        id_q[i]   <= id_d[i];
        gran_q[i] <= gran_d[i];
        tmo_q[i]  <= tmo_d[i];
      end
    end
  end

endmodule

// File: tb/tb_axi_riscv_lrsc_rsv_table.sv
module tb_axi_riscv_lrsc_rsv_table;

  localparam int unsigned NumRsv = 4;
  localparam int unsigned Tmo    = 8;
  localparam int unsigned Gl2    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, lr_valid, lr_ready, sc_valid, sc_ready;
  logic        sc_rsp_valid, sc_rsp_ready, sc_rsp_ok, wr_valid, evict;
  logic [3:0]  lr_id, sc_id;
  logic [63:0] lr_addr, sc_addr, wr_first, wr_last;
  logic [2:0]  rsv_count;

  axi_riscv_lrsc_rsv_table #(
    .AXI_ADDR_WIDTH (64),
    .AXI_ID_WIDTH   (4),
    .NUM_RSV        (NumRsv),
    .GRANULE_LOG2   (Gl2),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .lr_valid_i      (lr_valid),
    .lr_ready_o      (lr_ready),
    .lr_id_i         (lr_id),
    .lr_addr_i       (lr_addr),
    .sc_valid_i      (sc_valid),
    .sc_ready_o      (sc_ready),
    .sc_id_i         (sc_id),
    .sc_addr_i       (sc_addr),
    .sc_rsp_valid_o  (sc_rsp_valid),
    .sc_rsp_ready_i  (sc_rsp_ready),
    .sc_rsp_ok_o     (sc_rsp_ok),
    .wr_valid_i      (wr_valid),
    .wr_first_addr_i (wr_first),
    .wr_last_addr_i  (wr_last),
    .rsv_count_o     (rsv_count),
    .evict_o         (evict)
  );

  // Reference model: slots keyed by install edge number rather than a down-counter.
  bit          m_valid [NumRsv];
  logic [3:0]  m_id    [NumRsv];
  logic [63:0] m_gran  [NumRsv];
  longint      m_born  [NumRsv];
  int          m_rr;
  bit          m_rsp_v, m_rsp_ok, m_evict;
  longint      edge_no;
  int          n_total, n_bad;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_no);
    end
  endtask

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_next();
    longint e = edge_no + 1;
    bit     hs, ok;
    bit     nv [NumRsv];
    int     idx;
    if (rst) begin
      for (int i = 0; i < int'(NumRsv); i++) m_valid[i] = 1'b0;
      m_rr = 0; m_rsp_v = 1'b0; m_rsp_ok = 1'b0; m_evict = 1'b0;
      return;
    end
    hs = sc_valid && (!m_rsp_v || sc_rsp_ready);
    ok = 1'b0;
    if (hs) begin
      for (int i = 0; i < int'(NumRsv); i++) begin
        if (m_valid[i] && m_id[i] == sc_id && m_gran[i] == (sc_addr >> Gl2) &&
            (e - m_born[i]) < longint'(Tmo)) ok = 1'b1;
      end
    end
    for (int i = 0; i < int'(NumRsv); i++) begin
      nv[i] = m_valid[i];
      if (m_valid[i] && (e - m_born[i]) >= longint'(Tmo)) nv[i] = 1'b0;
      if (hs && m_valid[i] && (m_id[i] == sc_id || (ok && m_gran[i] == (sc_addr >> Gl2))))
        nv[i] = 1'b0;
      if (wr_valid && wr_last >= wr_first && m_valid[i] &&
          m_gran[i] >= (wr_first >> Gl2) && m_gran[i] <= (wr_last >> Gl2)) nv[i] = 1'b0;
    end
    for (int i = 0; i < int'(NumRsv); i++) m_valid[i] = nv[i];
    m_evict = 1'b0;
    if (lr_valid) begin
      idx = -1;
      for (int i = 0; i < int'(NumRsv); i++)
        if (idx < 0 && m_valid[i] && m_id[i] == lr_id) idx = i;
      for (int i = 0; i < int'(NumRsv); i++)
        if (idx < 0 && !m_valid[i]) idx = i;
      if (idx < 0) begin
        idx = m_rr;
        m_rr = (m_rr + 1) % int'(NumRsv);
        m_evict = 1'b1;
      end
      m_valid[idx] = 1'b1;
      m_id[idx]    = lr_id;
      m_gran[idx]  = lr_addr >> Gl2;
      m_born[idx]  = e;
    end
    if (hs) begin
      m_rsp_v  = 1'b1;
      m_rsp_ok = ok;
    end else if (sc_rsp_ready) begin
      m_rsp_v = 1'b0;
    end
  endtask

  task automatic cycle();
    int cnt;
    #1;
    check("lr_ready", lr_ready, !rst);
    check("sc_ready", sc_ready, !m_rsp_v || sc_rsp_ready);
    model_next();
    @(posedge clk);
    #1;
    edge_no++;
    check("rsp_valid", sc_rsp_valid, m_rsp_v);
    if (m_rsp_v) check("rsp_ok", sc_rsp_ok, m_rsp_ok);
    cnt = 0;
    for (int i = 0; i < int'(NumRsv); i++) cnt += int'(m_valid[i]);
    check("rsv_count", rsv_count, cnt);
    check("evict", evict, m_evict);
  endtask

  task automatic clear_inputs();
    rst = 1'b0; lr_valid = 1'b0; sc_valid = 1'b0; wr_valid = 1'b0; sc_rsp_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      clear_inputs();
      cycle();
    end
  endtask

  task automatic do_lr(input logic [3:0] id, input logic [63:0] addr);
    clear_inputs();
    lr_valid = 1'b1; lr_id = id; lr_addr = addr;
    cycle();
    clear_inputs();
  endtask

  task automatic do_sc(input string tag, input logic [3:0] id, input logic [63:0] addr,
                       input logic exp_ok);
    clear_inputs();
    sc_valid = 1'b1; sc_id = id; sc_addr = addr;
    cycle();
    check({tag, "_v"}, sc_rsp_valid, 1'b1);
    check(tag, sc_rsp_ok, exp_ok);
    clear_inputs();
  endtask

  task automatic do_snoop(input logic [63:0] first, input logic [63:0] last);
    clear_inputs();
    wr_valid = 1'b1; wr_first = first; wr_last = last;
    cycle();
    clear_inputs();
  endtask

  initial begin
    n_total = 0; n_bad = 0; edge_no = 0; m_rr = 0;
    m_rsp_v = 1'b0; m_rsp_ok = 1'b0; m_evict = 1'b0;
    for (int i = 0; i < int'(NumRsv); i++) m_valid[i] = 1'b0;
    lr_id = '0; lr_addr = '0; sc_id = '0; sc_addr = '0; wr_first = '0; wr_last = '0;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
    check("reset_ok", sc_rsp_ok, 1'b0);
    check("reset_count", rsv_count, 3'd0);
    clear_inputs();

    // Basic LR/SC, then a repeated SC fails.
    do_lr(4'd1, 64'h1000);
    idle(1);
    do_sc("sc_basic", 4'd1, 64'h1004, 1'b1);
    do_sc("sc_repeat", 4'd1, 64'h1004, 1'b0);
    idle(10);

    // Snoop overlapping the granule kills it; an adjacent snoop does not.
    do_lr(4'd1, 64'h1000);
    do_snoop(64'h0FF8, 64'h1000);
    do_sc("sc_snooped", 4'd1, 64'h1000, 1'b0);
    do_lr(4'd1, 64'h1000);
    do_snoop(64'h1008, 64'h1010);
    do_sc("sc_adjacent", 4'd1, 64'h1000, 1'b1);
    idle(10);

    // Five LRs into four slots: the fifth evicts slot 0.
    for (int i = 0; i < 5; i++) do_lr(4'(i), 64'(i * 8));
    check("evict_pulse", evict, 1'b1);
    check("evict_count", rsv_count, 3'd4);
    do_sc("sc_evicted", 4'd0, 64'h0, 1'b0);
    do_sc("sc_newest", 4'd4, 64'h20, 1'b1);
    idle(10);

    // A successful SC clears other IDs' reservations on the same granule.
    do_lr(4'd2, 64'h2000);
    do_lr(4'd3, 64'h2000);
    do_sc("sc_first", 4'd2, 64'h2000, 1'b1);
    do_sc("sc_second", 4'd3, 64'h2000, 1'b0);
    idle(10);

    // Timeout: usable for TIMEOUT_CYCLES-1 cycles after the install edge.
    do_lr(4'd5, 64'h3000);
    idle(5);
    do_sc("sc_tmo_live", 4'd5, 64'h3000, 1'b1);
    do_lr(4'd5, 64'h3000);
    idle(7);
    do_sc("sc_tmo_dead", 4'd5, 64'h3000, 1'b0);
    idle(10);

    // Response backpressure, then reset discards the pending response.
    do_lr(4'd6, 64'h4000);
    do_lr(4'd7, 64'h5000);
    clear_inputs();
    sc_valid = 1'b1; sc_id = 4'd6; sc_addr = 64'h4000; sc_rsp_ready = 1'b0;
    cycle();
    check("bp_first_ok", sc_rsp_ok, 1'b1);
    repeat (3) begin
      cycle();
      check("bp_ready", sc_ready, 1'b0);
      check("bp_valid", sc_rsp_valid, 1'b1);
      check("bp_ok", sc_rsp_ok, 1'b1);
    end
    check("bp_count", rsv_count, 3'd1);
    rst = 1'b1;
    cycle();
    check("rst_rsp_valid", sc_rsp_valid, 1'b0);
    check("rst_count", rsv_count, 3'd0);
    clear_inputs();

    // Random traffic over a small address/ID pool to force collisions.
    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(0, 199) == 0);
      lr_valid     = ($urandom_range(0, 2) == 0);
      lr_id        = 4'($urandom_range(0, 5));
      lr_addr      = 64'h100 + 64'($urandom_range(0, 31));
      sc_valid     = ($urandom_range(0, 2) == 0);
      sc_id        = 4'($urandom_range(0, 5));
      sc_addr      = 64'h100 + 64'($urandom_range(0, 31));
      sc_rsp_ready = ($urandom_range(0, 3) != 0);
      wr_valid     = ($urandom_range(0, 3) == 0);
      wr_first     = 64'h100 + 64'($urandom_range(0, 31));
      wr_last      = wr_first + 64'($urandom_range(0, 20)) - 64'd4;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
